imem_load_sequencer: RTL
========================

Name: imem_load_sequencer

Overview:
- Sequences the instruction memory and the fetch path.
- Loads a program word by word from a byte stream (UART RX) into instruction memory, with write addresses stepping by 4 to match PC byte addressing.
- Holds the PC during load, then releases the datapath in continuous-run or single-step mode.
- Stops the datapath when the halt word (all ones) is fetched.

Parameters:
- NBITS, 32: instruction/data width.
- CELDAS, 60: instruction memory cells, indexed by PC byte address.
- NB_ADDR, 6: address width, ceil(log2(CELDAS)).
- HALT_WORD, 32'hFFFFFFFF: end-of-program marker.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_load_start  input  1  one-cycle pulse requesting a program load.
- i_rx_valid  input  1  one-cycle strobe, a byte is available on i_rx_data.
- i_rx_data  input  8  received byte.
- i_run  input  1  pulse: enter continuous run.
- i_step  input  1  pulse: advance the datapath exactly one cycle.
- i_instruction  input  NBITS  instruction currently output by instruction memory.
- o_mem_we  output  1  instruction memory write enable.
- o_mem_addr  output  NB_ADDR  write address, byte address, multiple of 4.
- o_mem_data  output  NBITS  write data.
- o_pc_hold  output  1  forces PC to 0 and blocks fetch while loading.
- o_pc_enable  output  1  datapath/PC advance enable.
- o_loaded  output  1  program resident, waiting for run/step.
- o_done  output  1  halt word fetched, execution finished.
- o_error  output  1  sticky: memory filled without a halt word.
- o_word_count  output  NB_ADDR  words written in the current load.

Behaviour:
- Reset (i_reset low, asynchronous):
  - State = IDLE.
  - All outputs 0, except o_pc_hold = 1.
  - Byte counter, address and assembly register cleared.
- States: IDLE, RECV, WRITE, READY, RUN, DONE.
- IDLE:
  - o_pc_hold = 1.
  - i_load_start -> RECV; clear addr, byte count, word count and o_error.
- RECV:
  - o_pc_hold = 1.
  - Each i_rx_valid shifts i_rx_data into the assembly register, big-endian: first byte lands in [31:24].
  - 4th byte -> WRITE on the next edge.
  - i_load_start, i_run and i_step are ignored.
- WRITE: exactly one cycle.
  - o_mem_we = 1, o_mem_addr = addr, o_mem_data = assembled word.
  - o_word_count increments.
  - If word == HALT_WORD -> READY.
  - Else if addr == CELDAS-4 (last word slot) -> READY with o_error = 1.
  - Else addr += 4 -> RECV.
  - An i_rx_valid arriving in the WRITE cycle is captured as byte 0 of the next word. No byte is ever dropped inside a load.
- Outside RECV/WRITE, i_rx_valid is ignored.
- o_mem_we is high only in WRITE; o_mem_addr/o_mem_data are otherwise held at their last values.
- READY:
  - o_loaded = 1, o_pc_hold = 0.
  - i_run -> RUN.
  - i_step -> o_pc_enable high for exactly the next cycle; state stays READY.
  - i_run and i_step in the same cycle: run wins.
  - i_load_start -> RECV (reload).
- RUN:
  - o_pc_enable = 1 every cycle.
  - When i_instruction == HALT_WORD, o_pc_enable drops in the same cycle (combinational) -> DONE.
  - i_load_start, i_run and i_step are ignored.
  - Single-step, same rule: if i_instruction == HALT_WORD at the time of the step, no enable pulse is issued -> DONE.
- DONE:
  - o_done = 1, o_pc_enable = 0, o_pc_hold = 0.
  - i_load_start -> RECV, clearing o_done.
- o_error:
  - Set only in WRITE.
  - Cleared only by reset or an accepted i_load_start.
- o_word_count: holds its value after load until the next accepted i_load_start.
- Reset mid-load: any partial word is discarded and no write is issued. Memory contents are not touched.
- Address arithmetic:
  - NB_ADDR bits, step 4.
  - Never exceeds CELDAS-4; no wrap-around occurs.

Test Plan:
1. Reset, then pulse i_load_start. Send bytes 00 24 00 04, then FF FF FF FF.
   - Writes: addr 0 data 0x00240004, then addr 4 data 0xFFFFFFFF.
   - Result: o_word_count = 2, o_loaded = 1, o_error = 0.
2. Load 15 non-halt words (60 bytes).
   - Last write at addr 56.
   - Then READY with o_error = 1.
   - A 61st byte is ignored (no o_mem_we).
3. From READY, pulse i_step three times with i_instruction != HALT_WORD.
   - Exactly three single-cycle o_pc_enable pulses; state remains READY.
4. From READY, pulse i_run; present HALT_WORD on i_instruction after 5 cycles.
   - o_pc_enable high for exactly 5 cycles, low in the HALT cycle.
   - o_done = 1 the next cycle.
5. Drop i_reset low after 2 bytes of a word.
   - All outputs reset immediately, no o_mem_we.
   - After release, a new load starts at addr 0.
6. In READY, assert i_run and i_step together -> RUN.
   - In DONE, pulse i_load_start -> o_done = 0, o_pc_hold = 1, o_error cleared.

Source files
------------

// File: rtl/imem_load_sequencer_if.sv
// -----------------------------------------------------------------------------
// imem_load_sequencer_if
// Groups the signals between the load sequencer and its environment.
// Signal names follow the block's external naming (i_* into the sequencer,
// o_* out of it).
//   master : drives load/run/step requests, the UART byte stream and the fetched
//            instruction; observes memory writes and status.
//   slave  : the sequencer itself.
// -----------------------------------------------------------------------------
interface imem_load_sequencer_if #(
    parameter int NBITS   = 32,
    parameter int NB_ADDR = 6
) ();
    logic               i_load_start;
    logic               i_rx_valid;
    logic [7:0]         i_rx_data;
    logic               i_run;
    logic               i_step;
    logic [NBITS-1:0]   i_instruction;
    logic               o_mem_we;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NBITS-1:0]   o_mem_data;
    logic               o_pc_hold;
    logic               o_pc_enable;
    logic               o_loaded;
    logic               o_done;
    logic               o_error;
    logic [NB_ADDR-1:0] o_word_count;

    modport master (
        output i_load_start, i_rx_valid, i_rx_data, i_run, i_step, i_instruction,
        input  o_mem_we, o_mem_addr, o_mem_data, o_pc_hold, o_pc_enable,
               o_loaded, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_load_start, i_rx_valid, i_rx_data, i_run, i_step, i_instruction,
        output o_mem_we, o_mem_addr, o_mem_data, o_pc_hold, o_pc_enable,
               o_loaded, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/imem_load_sequencer.sv
// -----------------------------------------------------------------------------
// imem_load_sequencer
// Loads a program from a UART byte stream into instruction memory (big-endian
// word assembly, byte addresses stepping by 4), holds the PC during the load,
// then lets the datapath run continuously or single-step until the halt word
// is fetched.
// Ports:
//   i_clk    : system clock, rising edge
//   i_reset  : asynchronous active-low reset
//   bus      : imem_load_sequencer_if.slave (requests, byte stream, fetched
//              instruction in; memory write port and status out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, PC held, waiting for a load request
// RECV  | collecting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// READY | program resident, waiting for run or step
// RUN   | datapath advancing every cycle until the halt word is fetched
// DONE  | halt word fetched, datapath stopped
// -----------------------------------------------------------------------------
module imem_load_sequencer #(
    parameter int                NBITS     = 32,
    parameter int                CELDAS    = 60,
    parameter int                NB_ADDR   = 6,
    parameter logic [NBITS-1:0]  HALT_WORD = '1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    imem_load_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        READY = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(CELDAS - 4);
    localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(4);
    localparam logic [1:0]         LAST_BYTE = 2'd3;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [NBITS-1:0]   asm_q, asm_d;
    logic [NB_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [NBITS-1:0]   mem_data_q, mem_data_d;
    logic [NB_ADDR-1:0] word_cnt_q, word_cnt_d;
    logic               error_q, error_d;
    logic               step_q, step_d;

    logic               mem_we;
    logic               pc_hold;
    logic               pc_enable;
    logic               loaded;
    logic               done;
    logic               is_halt;
    logic [NBITS-1:0]   asm_shift;

    assign is_halt   = (bus.i_instruction == HALT_WORD);
    assign asm_shift = {asm_q[NBITS-9:0], bus.i_rx_data};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            word_cnt_q <= '0;
            error_q    <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            word_cnt_q <= word_cnt_d;
            error_q    <= error_d;
            step_q     <= step_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        word_cnt_d = word_cnt_q;
        error_d    = error_q;
        step_d     = 1'b0;
        mem_we     = 1'b0;
        pc_hold    = 1'b0;
        pc_enable  = 1'b0;
        loaded     = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                pc_hold = 1'b1;
                if (bus.i_load_start) begin
                    state_d    = RECV;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    error_d    = 1'b0;
                end
            end

            RECV: begin
                pc_hold = 1'b1;
                if (bus.i_rx_valid) begin
                    asm_d = asm_shift;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Latch the word and address so the write port holds
                        // them after the write cycle.
                        byte_cnt_d = '0;
                        mem_data_d = asm_shift;
                        mem_addr_d = addr_q;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            WRITE: begin
                pc_hold    = 1'b1;
                mem_we     = 1'b1;
                word_cnt_d = word_cnt_q + NB_ADDR'(1);
                // A byte arriving now is the first byte of the next word.
                if (bus.i_rx_valid) begin
                    asm_d      = asm_shift;
                    byte_cnt_d = 2'd1;
                end
                if (mem_data_q == HALT_WORD) begin
                    state_d = READY;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = READY;
                    error_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = RECV;
                end
            end

            READY: begin
                loaded    = 1'b1;
                pc_enable = step_q;
                if (bus.i_run) begin
                    state_d = RUN;
                end else if (bus.i_step) begin
                    // A step onto the halt word finishes without advancing.
                    if (is_halt) state_d = DONE;
                    else         step_d  = 1'b1;
                end else if (bus.i_load_start) begin
                    state_d    = RECV;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    error_d    = 1'b0;
                end
            end

            RUN: begin
                pc_enable = !is_halt;
                if (is_halt) state_d = DONE;
            end

            DONE: begin
                done = 1'b1;
                if (bus.i_load_start) begin
                    state_d    = RECV;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    error_d    = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_hold = 1'b1;
            end
        endcase
    end

    assign bus.o_mem_we     = mem_we;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_data   = mem_data_q;
    assign bus.o_pc_hold    = pc_hold;
    assign bus.o_pc_enable  = pc_enable;
    assign bus.o_loaded     = loaded;
    assign bus.o_done       = done;
    assign bus.o_error      = error_q;
    assign bus.o_word_count = word_cnt_q;

endmodule
